// File: rtl/minmax_tree_pipe.sv
// rtl/minmax_tree_pipe.sv - pipelined N-input min/max compare tree; define MINMAX_TREE_SIGNED_EN for signed compare
module minmax_tree_pipe #(
   parameter  int WIDTH  = 8,
   parameter  int NUM_IN = 4,
   localparam int LEVELS = $clog2(NUM_IN),
   localparam int IDX_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic                    in_mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [IDX_W-1:0]        out_idx
);

   // Tree is a heap: node 1 is the root, node n has children 2n and 2n+1,
   // leaves occupy heap slots LEAVES .. 2*LEAVES-1.
   localparam int LEAVES = 1 << LEVELS;
   localparam int NODES  = LEAVES - 1;

   // Stage that registers heap node n: the deepest internal level is stage 0.
   function automatic int node_stage(input int n);
      int depth;
      depth = 0;
      for (int k = n; k > 1; k = k >> 1) begin
         depth++;
      end
      return LEVELS - 1 - depth;
   endfunction

   // Decide whether the right (higher index) child wins; ties stay left.
   function automatic logic pick_right(input logic             pres_l,
                                       input logic             pres_r,
                                       input logic [WIDTH-1:0] data_l,
                                       input logic [WIDTH-1:0] data_r,
                                       input logic             mode);
      logic better;
`ifdef MINMAX_TREE_SIGNED_EN
      better = mode ? ($signed(data_r) > $signed(data_l))
                    : ($signed(data_r) < $signed(data_l));
`else
      better = mode ? (data_r > data_l) : (data_r < data_l);
`endif
      if (!pres_r) begin
         return 1'b0;
      end else if (!pres_l) begin
         return 1'b1;
      end
      return better;
   endfunction

   // Leaf operands (padded leaves are marked absent)
   logic [WIDTH-1:0] leaf_d [LEAVES];
   logic [IDX_W-1:0] leaf_i [LEAVES];
   logic             leaf_p [LEAVES];

   // Registered internal nodes and their combinational next values
   logic [WIDTH-1:0] node_d [1:NODES];
   logic [IDX_W-1:0] node_i [1:NODES];
   logic             node_p [1:NODES];
   logic [WIDTH-1:0] nxt_d  [1:NODES];
   logic [IDX_W-1:0] nxt_i  [1:NODES];
   logic             nxt_p  [1:NODES];
   logic             take_r [1:NODES];
   logic             node_mode [1:NODES];

   // Unified view of every heap slot: registered nodes plus raw leaves
   logic [WIDTH-1:0] src_d [1:2*LEAVES-1];
   logic [IDX_W-1:0] src_i [1:2*LEAVES-1];
   logic             src_p [1:2*LEAVES-1];

   // Per-stage beat bookkeeping; mode travels with its beat
   logic valid_q  [LEVELS];
   logic mode_q   [LEVELS];
   logic mode_src [LEVELS];

   logic en;

   assign out_valid = valid_q[LEVELS-1];
   assign out_data  = node_d[1];
   assign out_idx   = node_i[1];
   assign en        = !(out_valid && !out_ready);
   assign in_ready  = en;

   for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
      if (j < NUM_IN) begin : g_real
         assign leaf_d[j] = in_data[j*WIDTH +: WIDTH];
         assign leaf_p[j] = 1'b1;
      end else begin : g_pad
         assign leaf_d[j] = '0;
         assign leaf_p[j] = 1'b0;
      end
      assign leaf_i[j] = IDX_W'(j);
   end

   for (genvar n = 1; n <= NODES; n++) begin : g_node_mode
      localparam int STG = node_stage(n);
      assign node_mode[n] = mode_src[STG];
   end

   // Mode seen by each stage's compare logic: fresh input for stage 0, else the beat's carried mode
   always_comb begin
      mode_src[0] = in_mode;
      for (int s = 1; s < LEVELS; s++) begin
         mode_src[s] = mode_q[s-1];
      end
   end

   // Gather registered nodes and leaves into one heap-indexed view
   always_comb begin
      for (int n = 1; n <= NODES; n++) begin
         src_d[n] = node_d[n];
         src_i[n] = node_i[n];
         src_p[n] = node_p[n];
      end
      for (int j = 0; j < LEAVES; j++) begin
         src_d[LEAVES+j] = leaf_d[j];
         src_i[LEAVES+j] = leaf_i[j];
         src_p[LEAVES+j] = leaf_p[j];
      end
   end

   // Compare each node's two children and select the winner
   always_comb begin
      for (int n = 1; n <= NODES; n++) begin
         take_r[n] = pick_right(src_p[2*n], src_p[2*n+1], src_d[2*n], src_d[2*n+1], node_mode[n]);
         nxt_d[n]  = take_r[n] ? src_d[2*n+1] : src_d[2*n];
         nxt_i[n]  = take_r[n] ? src_i[2*n+1] : src_i[2*n];
         nxt_p[n]  = src_p[2*n] | src_p[2*n+1];
      end
   end

   // Advance every stage together when the output is not stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 1; n <= NODES; n++) begin
            node_d[n] <= '0;
            node_i[n] <= '0;
            node_p[n] <= 1'b0;
         end
         for (int s = 0; s < LEVELS; s++) begin
            valid_q[s] <= 1'b0;
            mode_q[s]  <= 1'b0;
         end
      end else if (en) begin
         for (int n = 1; n <= NODES; n++) begin
            node_d[n] <= nxt_d[n];
            node_i[n] <= nxt_i[n];
            node_p[n] <= nxt_p[n];
         end
         valid_q[0] <= in_valid;
         mode_q[0]  <= in_mode;
         for (int s = 1; s < LEVELS; s++) begin
            valid_q[s] <= valid_q[s-1];
            mode_q[s]  <= mode_q[s-1];
         end
      end
   end

endmodule

// File: tb/tb_minmax_tree_pipe.sv
// tb/tb_minmax_tree_pipe.sv - scoreboard bench for minmax_tree_pipe with NUM_IN = 4, 3 and 2
`timescale 1ns/1ps
module tb_minmax_tree_pipe;

   typedef struct packed { logic [7:0] d; logic [1:0] i; } res_t;
   typedef struct packed { logic en; logic [7:0] d; logic [1:0] i; } exp_t;
   localparam exp_t NONE = '{en: 1'b0, d: 8'h00, i: 2'd0};

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_mode, out_ready;
   logic [31:0] in_data;

   logic       a_ready, a_valid, b_ready, b_valid, c_ready, c_valid;
   logic [7:0] a_data, b_data, c_data;
   logic [1:0] a_idx, b_idx;
   logic [0:0] c_idx;

   int   errors = 0;
   int   checks = 0;
   int   bp_mode = 0;
   res_t q [3][$];
   exp_t lit [3];
   logic prev_stall [3];
   logic [7:0] prev_d [3];
   logic [1:0] prev_i [3];
   logic [7:0] ext [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

   always #5 clk = ~clk;

   minmax_tree_pipe #(.WIDTH(8), .NUM_IN(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
      .in_data(in_data), .in_mode(in_mode), .out_valid(a_valid),
      .out_ready(out_ready), .out_data(a_data), .out_idx(a_idx));

   minmax_tree_pipe #(.WIDTH(8), .NUM_IN(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready),
      .in_data(in_data[23:0]), .in_mode(in_mode), .out_valid(b_valid),
      .out_ready(out_ready), .out_data(b_data), .out_idx(b_idx));

   minmax_tree_pipe #(.WIDTH(8), .NUM_IN(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_ready),
      .in_data(in_data[15:0]), .in_mode(in_mode), .out_valid(c_valid),
      .out_ready(out_ready), .out_data(c_data), .out_idx(c_idx));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] dd, input logic [1:0] ii);
      return '{en: 1'b1, d: dd, i: ii};
   endfunction

   // Reference: linear scan, strict comparison keeps the lowest index on ties
   function automatic res_t model(input logic [31:0] d, input int n, input logic mode);
      int         best;
      logic [7:0] vb, vi;
      logic       better;
      best = 0;
      for (int i = 1; i < n; i++) begin
         vb = d[best*8 +: 8];
         vi = d[i*8 +: 8];
`ifdef MINMAX_TREE_SIGNED_EN
         better = mode ? ($signed(vi) > $signed(vb)) : ($signed(vi) < $signed(vb));
`else
         better = mode ? (vi > vb) : (vi < vb);
`endif
         if (better) best = i;
      end
      return '{d: d[best*8 +: 8], i: best[1:0]};
   endfunction

   task automatic mon(input int u, input logic ov, input logic [7:0] od, input logic [1:0] oi,
                      input logic ir, input int n);
      string nm;
      res_t  e;
      nm = (u == 0) ? "A" : (u == 1) ? "B" : "C";
      chk({nm, "_in_ready"}, 32'(ir), 32'(!(ov && !out_ready)));
      if (prev_stall[u]) begin
         chk({nm, "_hold_valid"}, 32'(ov), 32'd1);
         chk({nm, "_hold_data"}, 32'(od), 32'(prev_d[u]));
         chk({nm, "_hold_idx"}, 32'(oi), 32'(prev_i[u]));
      end
      prev_stall[u] = ov && !out_ready;
      prev_d[u] = od;
      prev_i[u] = oi;
      if (ov && out_ready) begin
         chk({nm, "_out_expected"}, 32'(q[u].size() != 0), 32'd1);
         if (q[u].size() != 0) begin
            e = q[u].pop_front();
            chk({nm, "_data"}, 32'(od), 32'(e.d));
            chk({nm, "_idx"}, 32'(oi), 32'(e.i));
         end
      end
      if (in_valid && ir) begin
         e = lit[u].en ? '{d: lit[u].d, i: lit[u].i} : model(in_data, n, in_mode);
         q[u].push_back(e);
      end
   endtask

   // Monitor: sample on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, a_valid, a_data, a_idx, a_ready, 4);
         mon(1, b_valid, b_data, b_idx, b_ready, 3);
         mon(2, c_valid, c_data, {1'b0, c_idx}, c_ready, 2);
      end
   end

   // Output backpressure driver
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
         endcase
      end
   end

   task automatic send(input logic [31:0] d, input logic m, input exp_t ea, input exp_t eb,
                       input exp_t ec, output int waits);
      logic acc;
      in_data = d;
      in_mode = m;
      lit[0] = ea;
      lit[1] = eb;
      lit[2] = ec;
      in_valid = 1'b1;
      waits = 0;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = a_ready;
         @(posedge clk);
         #1;
         waits++;
      end
      chk("send_accepted", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      int          lat;
      logic [31:0] d;
      rst_n = 1'b1;
      in_valid = 1'b0;
      in_mode = 1'b0;
      in_data = '0;
      for (int u = 0; u < 3; u++) begin
         lit[u] = NONE;
         prev_stall[u] = 1'b0;
      end
      #1 rst_n = 1'b0;
      #1;
      chk("rst_a_valid", 32'(a_valid), 32'd0);
      chk("rst_a_data", 32'(a_data), 32'd0);
      chk("rst_a_idx", 32'(a_idx), 32'd0);
      chk("rst_a_in_ready", 32'(a_ready), 32'd1);
      chk("rst_b_valid", 32'(b_valid), 32'd0);
      chk("rst_c_valid", 32'(c_valid), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Tie resolution and mode select
      send(32'h03090305, 1'b0, mk(8'd3, 2'd1), mk(8'd3, 2'd1), NONE, w);
      send(32'h03090305, 1'b1, mk(8'd9, 2'd2), mk(8'd9, 2'd2), NONE, w);
      idle(3);

      // Back-to-back stream with alternating mode
      send(32'h04030201, 1'b0, mk(8'h01, 2'd0), NONE, NONE, w);
      chk("stream_wait0", 32'(w), 32'd1);
      send(32'h05060708, 1'b1, mk(8'h08, 2'd0), NONE, NONE, w);
      chk("stream_wait1", 32'(w), 32'd1);
`ifdef MINMAX_TREE_SIGNED_EN
      send(32'h001000FF, 1'b0, mk(8'hFF, 2'd0), NONE, NONE, w);
      chk("stream_wait2", 32'(w), 32'd1);
      send(32'h8001807F, 1'b1, mk(8'h7F, 2'd0), NONE, NONE, w);
      chk("stream_wait3", 32'(w), 32'd1);
`else
      send(32'h001000FF, 1'b0, mk(8'h00, 2'd1), NONE, NONE, w);
      chk("stream_wait2", 32'(w), 32'd1);
      send(32'h8001807F, 1'b1, mk(8'h80, 2'd1), NONE, NONE, w);
      chk("stream_wait3", 32'(w), 32'd1);
`endif
      idle(3);

      // Padded tree (NUM_IN=3): padded leaf must never win
      send(32'h00040207, 1'b0, NONE, mk(8'd2, 2'd1), NONE, w);
      send(32'h00040207, 1'b1, NONE, mk(8'd7, 2'd0), NONE, w);
      send(32'h00000000, 1'b0, NONE, mk(8'h00, 2'd0), NONE, w);
      send(32'h00FFFFFF, 1'b1, NONE, mk(8'hFF, 2'd0), NONE, w);
      idle(3);

      // Signedness on the two-input instance
`ifdef MINMAX_TREE_SIGNED_EN
      send(32'h00000180, 1'b0, NONE, NONE, mk(8'h80, 2'd0), w);
      send(32'h00000180, 1'b1, NONE, NONE, mk(8'h01, 2'd1), w);
`else
      send(32'h00000180, 1'b0, NONE, NONE, mk(8'h01, 2'd1), w);
      send(32'h00000180, 1'b1, NONE, NONE, mk(8'h80, 2'd0), w);
`endif
      idle(3);

      // Backpressure: fill the pipe with output stalled, then release
      bp_mode = 1;
      idle(2);
      send($urandom, 1'($urandom_range(0, 1)), NONE, NONE, NONE, w);
      send($urandom, 1'($urandom_range(0, 1)), NONE, NONE, NONE, w);
      in_data = $urandom;
      in_mode = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(a_ready), 32'd0);
         chk("bp_out_valid", 32'(a_valid), 32'd1);
      end
      bp_mode = 0;
      @(posedge clk);
      #1;
      send(in_data, in_mode, NONE, NONE, NONE, w);
      idle(4);

      // Randomized traffic with random backpressure
      bp_mode = 2;
      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 2))
            0: d = $urandom;
            1: d = $urandom & 32'h03030303;
            default: for (int b = 0; b < 4; b++) d[b*8 +: 8] = ext[$urandom_range(0, 3)];
         endcase
         send(d, 1'($urandom_range(0, 1)), NONE, NONE, NONE, w);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      bp_mode = 0;
      idle(6);

      // Reset with beats in flight
      send($urandom, 1'b0, NONE, NONE, NONE, w);
      send($urandom, 1'b1, NONE, NONE, NONE, w);
      #1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("midrst_a_valid", 32'(a_valid), 32'd0);
      chk("midrst_a_data", 32'(a_data), 32'd0);
      chk("midrst_a_idx", 32'(a_idx), 32'd0);
      chk("midrst_b_valid", 32'(b_valid), 32'd0);
      chk("midrst_c_valid", 32'(c_valid), 32'd0);
      for (int u = 0; u < 3; u++) begin
         q[u].delete();
         prev_stall[u] = 1'b0;
      end
      #8 rst_n = 1'b1;
      idle(4);

      // Latency of a fresh beat after reset
      in_data = 32'h11_42_07_33;
      in_mode = 1'b1;
      lit[0] = mk(8'h42, 2'd2);
      lit[1] = NONE;
      lit[2] = NONE;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (a_valid) break;
         @(posedge clk);
         lat++;
      end
      chk("latency_edges_after_accept", 32'(lat), 32'd1);
      idle(10);

      chk("A_drain_empty", 32'(q[0].size()), 32'd0);
      chk("B_drain_empty", 32'(q[1].size()), 32'd0);
      chk("C_drain_empty", 32'(q[2].size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/minmax_tree_pipe.md
Name: minmax_tree_pipe

Overview:
- Parametrised, pipelined N-input min/max selector built as a binary compare tree with one register stage per tree level.
- Reports the selected value and the index of the input that produced it.
- Mode (min or max) is chosen per beat.
- Valid/ready streaming handshake with full-pipeline stall on output backpressure; used wherever multi-channel extremum selection is needed in the datapath.

Parameters:
- WIDTH, 8, bit width of each input operand and of out_data.
- NUM_IN, 4, number of input operands; legal range 2..64, not required to be a power of two.
- Derived LEVELS = clog2(NUM_IN), pipeline depth in cycles.
- Derived IDX_W = clog2(NUM_IN), width of out_idx.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_mode valid this cycle.
- in_ready  output  1  block accepts a beat when in_valid && in_ready.
- in_data  input  NUM_IN*WIDTH  operand i occupies bits [i*WIDTH +: WIDTH].
- in_mode  input  1  0 = select minimum, 1 = select maximum; sampled with the beat.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result when out_valid && out_ready.
- out_data  output  WIDTH  selected extremum.
- out_idx  output  IDX_W  index of the winning operand.

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, out_data=0, out_idx=0.
  - All stage valid bits cleared; all stage data/idx/mode registers cleared.
  - Release is synchronous to clk; first acceptance is possible on the first edge after release.
- Global advance enable: en = !(out_valid && !out_ready). in_ready = en, combinational from out_valid/out_ready only, never from in_valid.
- When en=1, every stage loads from the previous stage (stage 0 from the inputs) on the clock edge. Valid bits move with the data, so bubbles propagate.
- When en=0, all stage registers hold, including out_data, out_idx and out_valid.
- Latency: a beat accepted at edge k appears on the outputs after edge k+LEVELS-1. With no stall it is visible for one cycle starting LEVELS cycles after acceptance. Throughput is 1 beat/cycle when out_ready=1.
- Tree structure:
  - Leaves are padded to 2^LEVELS.
  - Each leaf carries {present, data, idx}; padded leaves have present=0.
  - Each node selects between left (lower index) and right child:
    - If exactly one child is present, that child wins.
    - If both are present, min mode picks right only if right < left; max mode picks right only if right > left.
    - Ties go to the lower index.
  - A padded leaf never wins against a real operand, regardless of its data value.
- Comparison is unsigned by default.
- Mode is registered and carried stage-by-stage with its beat, so consecutive beats may use different modes with no bubble.
- Data of non-valid stages is don't-care internally. out_data/out_idx while out_valid=0 is unspecified but stable under stall.
- Reset asserted mid-operation discards all in-flight beats; no partial result is emitted after release.

Optional Feature:
- Macro MINMAX_TREE_SIGNED_EN.
- Defined: every node comparison treats operands as two's-complement signed WIDTH-bit values. Tie rule and padding rule are unchanged.
- Undefined: unsigned comparison.
- Port list, latency and handshake are identical in both builds.

Test Plan:
- NUM_IN=4, WIDTH=8, out_ready=1. Beat {a0=5,a1=3,a2=9,a3=3}, mode=0 -> after 2 cycles out_valid=1, out_data=3, out_idx=1 (tie resolved to lower index). Same data with mode=1 -> out_data=9, out_idx=2.
- Back-to-back stream of 4 beats with alternating mode (0,1,0,1) and data {1,2,3,4},{8,7,6,5},{0xFF,0x00,0x10,0x00},{0x7F,0x80,0x01,0x80} -> results in order (1,0),(8,0),(0x00,1),(0x80,1); out_valid high on 4 consecutive cycles; in_ready never drops.
- Backpressure: hold out_ready=0 for 3 cycles while a result is valid -> out_data/out_idx/out_valid hold, in_ready=0, in_valid beats are not accepted. Raise out_ready -> remaining results emerge in order with none lost or duplicated.
- NUM_IN=3 (padded): beat {7,2,4}: mode=0 -> 2/idx1; mode=1 -> 7/idx0. Beats {0,0,0} with mode=0 and {0xFF,0xFF,0xFF} with mode=1 -> idx0, the padded leaf never selected.
- Reset mid-flight: accept 2 beats, assert rst_n low for one cycle before either emerges -> out_valid=0, out_data=0, out_idx=0 immediately. After release no stale results appear; a new beat returns the correct result with latency LEVELS.
- With MINMAX_TREE_SIGNED_EN, NUM_IN=2: {0x80,0x01}, mode=0 -> out_data=0x80, idx0; mode=1 -> 0x01, idx1. Without the macro the same beats give 0x01/idx1 and 0x80/idx0.
